// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: shared FSM states, counter width and round-robin pick function for the arbiter
package wshb_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;
    localparam int QCNT_W = 8;
    localparam int MAX_N = 8;
    function automatic logic [2:0] rr_pick(input logic [MAX_N-1:0] req, input logic [2:0] last, input int n);
        logic [2:0] idx;
        logic [2:0] j;
        idx = 3'd0;
        for (int i = MAX_N; i >= 1; i--) begin
            j = 3'((int'(last) + i) % n);
            if (i <= n && req[j]) idx = j;
        end
        return idx;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first set request after the last winner, searching upward modulo N
module rr_picker
    import wshb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    assign idx_o   = IW'(rr_pick(MAX_N'(req_i), 3'(last_i), N));
    assign valid_o = |req_i;
endmodule

// File: rtl/wshb_rr_arbiter.sv
// wshb_rr_arbiter: round-robin Wishbone arbiter with urgency boost and transfer quantum
module wshb_rr_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int QUANTUM = 16,
    parameter int IW      = $clog2(N)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      urgent,
    input  logic              ack,
    output logic [N-1:0]      gnt,
    output logic [IW-1:0]     gnt_idx,
    output logic              busy,
    output logic [QCNT_W-1:0] qcnt
);
    state_e             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      last_q, last_d;
    logic               busy_q, busy_d;
    logic [QCNT_W-1:0]  qcnt_q, qcnt_d;
    logic [IW-1:0]      u_idx, p_idx, win;
    logic               u_vld, p_vld;
    logic               others, urg_other, quota_hit;
    logic [QCNT_W-1:0]  qcnt_inc;

    rr_picker #(.N(N), .IW(IW)) u_pick_urgent (
        .req_i   (req & urgent),
        .last_i  (last_q),
        .idx_o   (u_idx),
        .valid_o (u_vld)
    );

    rr_picker #(.N(N), .IW(IW)) u_pick_plain (
        .req_i   (req),
        .last_i  (last_q),
        .idx_o   (p_idx),
        .valid_o (p_vld)
    );

    assign win       = u_vld ? u_idx : p_idx;
    assign others    = |(req & ~gnt_q);
    assign urg_other = |(req & urgent & ~gnt_q);
    assign quota_hit = int'(qcnt_q) + 1 >= QUANTUM;
    assign qcnt_inc  = (qcnt_q == '1) ? qcnt_q : qcnt_q + 1'b1;

    // next state: hold the owner until it releases or must yield, then a one-cycle gap before re-arbitrating
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        busy_d  = busy_q;
        qcnt_d  = qcnt_q;
        case (state_q)
            OWN: begin
                if (ack) qcnt_d = qcnt_inc;
                if (!req[idx_q] || (ack && others && (quota_hit || urg_other))) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                if (p_vld) begin
                    state_d = OWN;
                    gnt_d   = N'(1) << win;
                    idx_d   = win;
                    last_d  = win;
                    busy_d  = 1'b1;
                    qcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    // all outputs are flops; reset leaves the pointer at N-1 so master 0 wins first
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IW'(N - 1);
            busy_q  <= 1'b0;
            qcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            qcnt_q  <= qcnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign busy    = busy_q;
    assign qcnt    = qcnt_q;
endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// tb_wshb_rr_arbiter: directed vector table plus hand sequences for the round-robin arbiter
module tb_wshb_rr_arbiter;
    logic       sys_clk;
    logic       sys_rst_n;
    logic [1:0] req;
    logic [1:0] urgent;
    logic       ack;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       busy;
    logic [7:0] qcnt;
    int         errors;
    int         checks;

    typedef struct {
        logic [1:0] req;
        logic [1:0] urg;
        logic       ack;
        logic [1:0] gnt;
        logic       busy;
        logic       idx;
        logic [7:0] q;
    } vec_t;

    vec_t v[27];

    wshb_rr_arbiter #(.N(2), .QUANTUM(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .urgent    (urgent),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .busy      (busy),
        .qcnt      (qcnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        v[0]  = '{2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 8'd0};
        v[1]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 8'd1};
        v[2]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 8'd2};
        v[3]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 8'd3};
        v[4]  = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 8'd4};
        v[5]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 8'd0};
        v[6]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 8'd1};
        v[7]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 8'd2};
        v[8]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 8'd3};
        v[9]  = '{2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 8'd4};
        v[10] = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 8'd0};
        v[11] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 8'd0};
        v[12] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 8'd1};
        v[13] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 8'd1};
        v[14] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 8'd1};
        v[15] = '{2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 8'd0};
        v[16] = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 8'd1};
        v[17] = '{2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 8'd2};
        v[18] = '{2'b11, 2'b10, 1'b0, 2'b01, 1'b1, 1'b0, 8'd2};
        v[19] = '{2'b11, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 8'd3};
        v[20] = '{2'b11, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 8'd0};
        v[21] = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 8'd1};
        v[22] = '{2'b11, 2'b01, 1'b0, 2'b10, 1'b1, 1'b1, 8'd1};
        v[23] = '{2'b11, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 8'd2};
        v[24] = '{2'b11, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 8'd0};
        v[25] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 8'd0};
        v[26] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 8'd0};

        sys_rst_n = 1'b0;
        req       = 2'b11;
        urgent    = 2'b00;
        ack       = 1'b0;
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        chk("rst_qcnt", 32'(qcnt), 32'h0);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            req    = v[i].req;
            urgent = v[i].urg;
            ack    = v[i].ack;
            tick();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v[i].gnt));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v[i].busy));
            chk($sformatf("v%0d_idx", i), 32'(gnt_idx), 32'(v[i].idx));
            chk($sformatf("v%0d_qcnt", i), 32'(qcnt), 32'(v[i].q));
        end

        req    = 2'b10;
        urgent = 2'b00;
        ack    = 1'b0;
        tick();
        chk("solo_grant", 32'({busy, gnt}), 32'b110);
        ack = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk($sformatf("solo_c%0d", i), 32'({busy, gnt, gnt_idx}), 32'b1101);
        end
        chk("solo_qcnt_sat", 32'(qcnt), 32'd255);

        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_qcnt", 32'(qcnt), 32'h0);
        chk("arst_idx", 32'(gnt_idx), 32'h0);
        tick();
        chk("arst_hold", 32'({busy, gnt}), 32'h0);
        sys_rst_n = 1'b1;
        req = 2'b11;
        ack = 1'b0;
        tick();
        chk("arst_resume_gnt", 32'(gnt), 32'b01);
        chk("arst_resume_busy", 32'(busy), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
